// File: rtl/mul_ctrl_if.sv
// CPU-side bus of the HI/LO multiply controller: multiply requests,
// MTHI/MTLO writes and the architectural HI/LO read-back with status.
interface mul_ctrl_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  // The CPU pipeline drives requests and observes results.
  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  // The controller accepts requests and owns HI/LO.
  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences a pipelined signed 32x32 multiplier and owns the
// HI/LO architectural registers.
// Flow: IDLE -> RUN (MUL_LAT cycles) -> WB (write HI/LO, pulse done) -> IDLE.
// Optional feature: define MUL_CTRL_MADD_EN to decode op as MADD
// ({hi,lo} += a*b); without it every operation is a plain MULT.
module mul_ctrl #(
  parameter int unsigned MUL_LAT = 6  // multiplier latency in edges, 1..15
) (
  input  logic        clk,
  input  logic        reset,
  mul_ctrl_if.slave   bus,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        mul_rst_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        done_q, done_d;
  logic [63:0] wb_val;

`ifdef MUL_CTRL_MADD_EN
  logic        op_q, op_d;

  // Value written back to HI/LO: fresh product or accumulate (mod 2^64).
  always_comb begin
    wb_val = op_q ? ({hi_q, lo_q} + mul_z) : mul_z;
  end
`else
  // Without accumulate support the op bit has no meaning.
  logic unused_op;
  assign unused_op = bus.op;

  // Value written back to HI/LO: always the fresh product.
  always_comb begin
    wb_val = mul_z;
  end
`endif

  // State register of the sequencing FSM.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode for all controller registers.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    done_d  = 1'b0;
`ifdef MUL_CTRL_MADD_EN
    op_d    = op_q;
`endif

    unique case (state_q)
      IDLE: begin
        // MTHI/MTLO land here; they also apply alongside an accepted start,
        // so a following MADD accumulates onto the freshly written value.
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        // A flush in the same cycle kills the request.
        if (bus.start && !bus.flush) begin
          mul_a_d = bus.a;
          mul_b_d = bus.b;
          cnt_d   = LAT;
          state_d = RUN;
`ifdef MUL_CTRL_MADD_EN
          op_d    = bus.op;
`endif
        end
      end

      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = WB;
        end
      end

      WB: begin
        state_d = IDLE;
        if (!bus.flush) begin
          {hi_d, lo_d} = wb_val;
          done_d       = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; operands stay put until the next accepted start
  // because the multiplier re-samples them every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      done_q  <= done_d;
    end
  end

`ifdef MUL_CTRL_MADD_EN
  // Operation latched with the request, consumed at write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= 1'b0;
    end else begin
      op_q <= op_d;
    end
  end
`endif

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_rst_n = ~reset;

endmodule
